// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   state_t             : responder FSM states (IDLE, WAIT, RESP)
//   WORD_LSB            : lowest byte-address bit that selects a word
//   ALIGN_MASK          : byte-address bits that must be zero for a word access
//   DEFAULT_WAIT_CYCLES : default wait states between acceptance and response
//   addr_error()        : misaligned or out-of-range check for a byte address
// Optional feature macro used by the users of this package: DMEM_BYTE_STROBE_EN
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_LSB            = 2;
  localparam logic [1:0]  ALIGN_MASK          = 2'b11;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned BYTES_PER_WORD      = 4;

  // True when the byte address is not word aligned or names a word at or
  // beyond mem_size.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input int unsigned mem_size);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[WORD_LSB-1:0] & ALIGN_MASK) != 2'b00;
    out_of_range = {2'b00, addr[31:WORD_LSB]} >= mem_size;
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word storage for dmem_responder: synchronous byte-masked write,
// combinational read. Contents are not reset.
// Parameters:
//   MEMORY_SIZE : number of 32-bit words
//   ADDR_W      : word-index width
// Ports:
//   clk   in   clock, rising edge
//   we    in   write enable
//   wstrb in   [3:0] byte write mask (bit i enables byte i)
//   addr  in   [ADDR_W-1:0] word index (shared by read and write)
//   wdata in   [31:0] write data
//   rdata out  [31:0] combinational read data at addr
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = 512,
  parameter int unsigned ADDR_W      = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEMORY_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
        if (wstrb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for LW/SW data accesses over valid/ready request and
// response channels. One transaction at a time, WAIT_CYCLES wait states
// between acceptance and the commit that produces the response.
// Parameters:
//   MEMORY_SIZE : number of 32-bit words stored
//   WAIT_CYCLES : wait states between acceptance and response (0..15)
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (decoded from state)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   [31:0] byte address
//   req_wdata  in   [31:0] store data
//   req_wstrb  in   [3:0] store byte enables (only with DMEM_BYTE_STROBE_EN)
//   resp_valid out  response present
//   resp_ready in   initiator accepts the response
//   resp_rdata out  [31:0] load data; 0 for stores and errors
//   resp_err   out  misaligned or out-of-range access
// Configuration macro: DMEM_BYTE_STROBE_EN adds req_wstrb; without it stores
// write the full word.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = 512,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned ADDR_W    = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        accept;
  logic        commit;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [3:0]  wstrb_q;

  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_write;
  logic [3:0]  c_wstrb;
  logic        c_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [3:0]  req_strb;

`ifdef DMEM_BYTE_STROBE_EN
  assign req_strb = req_wstrb;
`else
  assign req_strb = '1;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);

  // With zero wait states the commit happens on the acceptance edge, so the
  // live request is used; otherwise the latched copy is.
  always_comb begin
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_write = write_q;
    c_wstrb = wstrb_q;
    if (state == IDLE) begin
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_write = req_write;
      c_wstrb = req_strb;
    end
  end

  assign c_err = addr_error(c_addr, MEMORY_SIZE);

  // The FSM sits in IDLE while reset is held, so a zero-wait-state commit
  // must be masked explicitly to keep reset from writing the array.
  assign mem_we = commit && c_write && !c_err && rst;

  dmem_array #(
    .MEMORY_SIZE (MEMORY_SIZE),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .wstrb (c_wstrb),
    .addr  (c_addr[WORD_LSB +: ADDR_W]),
    .wdata (c_wdata),
    .rdata (mem_rdata)
  );

  // ------------------------------------------ request latch and counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wstrb_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= WAIT_INIT;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
        wstrb_q <= req_strb;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // ------------------------------------------------- response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= c_err;
        resp_rdata <= (c_err || c_write) ? '0 : mem_rdata;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share the clock and reset: u_dut0 with two wait states and
// u_dut1 with none. A transaction-level model (memory image plus acceptance
// edge per instance) predicts every output each cycle; directed sequences
// pin the model with hand-computed values, then randomized traffic runs on
// both instances at once.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int unsigned MEM = 512;
  localparam int unsigned W0  = 2;
  localparam int unsigned W1  = 0;
`ifdef DMEM_BYTE_STROBE_EN
  localparam bit STRB_ON = 1'b1;
`else
  localparam bit STRB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wstrb  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit started     = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.MEMORY_SIZE(MEM), .WAIT_CYCLES(W0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_write  (req_write[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb  (req_wstrb[0]),
`endif
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0])
  );

  dmem_responder #(.MEMORY_SIZE(MEM), .WAIT_CYCLES(W1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_write  (req_write[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb  (req_wstrb[1]),
`endif
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? int'(W0) : int'(W1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no handshake within 64 cycles, expected a handshake", nm);
  endtask

  // ------------------------------------------------------------- model
  // A transaction is accepted on edge acc; its access takes effect on edge
  // acc+W, after which the response is visible until the handshake edge.
  bit          m_busy  [2];
  bit          m_done  [2];
  int          m_acc   [2];
  logic        m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_strb  [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  logic [31:0] mm      [2][MEM];
  int          m_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          if (m_done[i] && resp_ready[i]) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
          end
        end else if (req_valid[i]) begin
          m_busy[i]  = 1'b1;
          m_acc[i]   = cyc;
          m_wr[i]    = req_write[i];
          m_addr[i]  = req_addr[i];
          m_wdata[i] = req_wdata[i];
          m_strb[i]  = STRB_ON ? req_wstrb[i] : 4'hF;
        end
        if (m_busy[i] && !m_done[i] && cyc == m_acc[i] + lat(i)) begin
          m_done[i]  = 1'b1;
          m_err[i]   = (m_addr[i][1:0] != 2'b00) || ((m_addr[i] >> 2) >= MEM);
          m_rdata[i] = 32'h0;
          if (!m_err[i]) begin
            m_idx = int'(m_addr[i] >> 2);
            if (m_wr[i]) begin
              for (int b = 0; b < 4; b++) begin
                if (m_strb[i][b]) mm[i][m_idx][8*b +: 8] = m_wdata[i][8*b +: 8];
              end
            end else begin
              m_rdata[i] = mm[i][m_idx];
            end
          end
        end
      end
    end
  end

  // ----------------------------------------------------------- compare
  bit vis [2];
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        vis[i] = m_busy[i] && m_done[i];
        chk($sformatf("u%0d.req_ready@%0d", i, cyc),  32'(req_ready[i]),  32'(!m_busy[i]));
        chk($sformatf("u%0d.resp_valid@%0d", i, cyc), 32'(resp_valid[i]), 32'(vis[i]));
        chk($sformatf("u%0d.resp_rdata@%0d", i, cyc), resp_rdata[i], vis[i] ? m_rdata[i] : 32'h0);
        chk($sformatf("u%0d.resp_err@%0d", i, cyc),   32'(resp_err[i]),   vis[i] ? 32'(m_err[i]) : 32'h0);
      end
    end
  end

  // ------------------------------------------------------------ driver
  // Called at posedge+#1. Returns the acceptance edge, the edge after which
  // resp_valid was first seen, the handshake edge and the response payload.
  task automatic txn(input int i, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input int hold, input bit junk,
                     output int acc_e, output int first_e, output int hs_e,
                     output logic [31:0] rd, output logic er);
    int t;
    int seen;
    bit ok;
    acc_e = -1; first_e = -1; hs_e = -1; rd = '0; er = 1'b0;
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a;
    req_wdata[i] = d; req_wstrb[i] = s; resp_ready[i] = 1'b0;
    t = 0; ok = 1'b0;
    while (!ok && t < 64) begin
      ok = req_ready[i];
      @(posedge clk); #1; t++;
    end
    if (!ok) begin
      tmo($sformatf("u%0d.accept", i));
      req_valid[i] = 1'b0;
      return;
    end
    acc_e = cyc;
    if (!junk) req_valid[i] = 1'b0;
    seen = 0; t = 0; ok = 1'b0;
    while (!ok && t < 64) begin
      if (junk) begin
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_write[i] = 1'($urandom_range(1, 0));
      end
      resp_ready[i] = (seen >= hold);
      if (resp_valid[i]) begin
        if (first_e < 0) first_e = cyc;
        ok = resp_ready[i];
        rd = resp_rdata[i];
        er = resp_err[i];
        seen++;
      end
      @(posedge clk); #1; t++;
    end
    if (!ok) tmo($sformatf("u%0d.response", i));
    hs_e = cyc;
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b0;
  endtask

  function automatic logic [31:0] fill_val(input int i, input int k);
    return 32'hA500_0000 | (32'(i) << 16) | 32'(k);
  endfunction

  task automatic fill(input int i);
    int a, f, h;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 16; k++) begin
      txn(i, 1'b1, 32'(k * 4), fill_val(i, k), 4'hF, 0, 1'b0, a, f, h, rd, er);
    end
  endtask

  task automatic rand_run(input int i, input int n);
    int a, f, h, r, gap;
    logic [31:0] addr, rd;
    logic er;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(9, 0);
      if (r < 7)       addr = 32'($urandom_range(15, 0)) << 2;
      else if (r == 7) addr = (32'($urandom_range(15, 0)) << 2) | 32'($urandom_range(3, 1));
      else if (r == 8) addr = 32'(4 * MEM) + (32'($urandom_range(63, 0)) << 2);
      else             addr = $urandom | 32'h0000_1000;
      txn(i, 1'($urandom_range(1, 0)), addr, $urandom, 4'($urandom_range(15, 0)),
          $urandom_range(3, 0), 1'($urandom_range(1, 0)), a, f, h, rd, er);
      gap = $urandom_range(2, 0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1 ms, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a0, f0, h0, a1, f1, h1, a2, f2, h2;
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_wstrb[i] = 4'hF; resp_ready[i] = 1'b0;
    end
    #2 rst = 1'b0;
    #1 started = 1'b1;
    chk("reset.req_ready",  32'(req_ready[0]),  32'h1);
    chk("reset.resp_valid", 32'(resp_valid[0]), 32'h0);
    chk("reset.resp_rdata", resp_rdata[0],      32'h0);
    chk("reset.resp_err",   32'(resp_err[0]),   32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    fork
      fill(0);
      fill(1);
    join

    // Store then load with two wait states: visible after edge acc+2.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("w2.store_latency", 32'(f0 - a0), 32'd2);
    chk("w2.store_rdata", rd, 32'h0);
    chk("w2.store_err", 32'(er), 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("w2.load_rdata", rd, 32'hDEAD_BEEF);

    // Backpressure: five stalled cycles, concurrent junk requests ignored.
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, a0, f0, h0, rd, er);
    chk("bp.hold_cycles", 32'(h0 - f0), 32'd6);
    chk("bp.rdata", rd, 32'hDEAD_BEEF);
    chk("bp.idle_after", 32'(req_ready[0]), 32'h1);

    // Error cases.
    txn(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("err.misaligned_err", 32'(er), 32'h1);
    chk("err.misaligned_rdata", rd, 32'h0);
    txn(0, 1'b1, 32'(4 * MEM), 32'h1234_5678, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("err.range_err", 32'(er), 32'h1);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("err.word0_unchanged", rd, 32'hA500_0000);

    // Reset while the store to 0x30 is still waiting: no write happens.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'h0BAD_F00D; req_wstrb[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rstwait.req_ready",  32'(req_ready[0]),  32'h1);
    chk("rstwait.resp_valid", 32'(resp_valid[0]), 32'h0);
    chk("rstwait.resp_err",   32'(resp_err[0]),   32'h0);
    txn(0, 1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("rstwait.no_write", rd, 32'hA500_000C);

    // Zero wait states, back to back with resp_ready high.
    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("w0.rdata0", rd, 32'hA501_0000);
    txn(1, 1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, a1, f1, h1, rd, er);
    chk("w0.rdata1", rd, 32'hA501_0001);
    txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, a2, f2, h2, rd, er);
    chk("w0.rdata2", rd, 32'hA501_0002);
    chk("w0.latency", 32'(f2 - a2), 32'd0);
    chk("w0.spacing01", 32'(a1 - a0), 32'd2);
    chk("w0.spacing12", 32'(a2 - a1), 32'd2);

`ifdef DMEM_BYTE_STROBE_EN
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, a0, f0, h0, rd, er);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("strb.merged", rd, 32'h11BB_33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0, a0, f0, h0, rd, er);
    chk("strb.zero_err", 32'(er), 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, a0, f0, h0, rd, er);
    chk("strb.zero_unchanged", rd, 32'h11BB_33DD);
`endif

    fork
      rand_run(0, 150);
      rand_run(1, 150);
    join

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
